dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request acceptance to first resp_valid (legal range 1..15).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset; synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder can accept a request.
REQ-007 SHALL have port req_we  input  1  meaning store when 1, load when 0.
REQ-008 SHALL have port req_funct3  input  3  meaning RV32I load/store size/sign code.
REQ-009 SHALL have port req_addr  input  WIDTH  meaning byte address.
REQ-010 SHALL have port req_wdata  input  WIDTH  meaning store data, LSB-justified.
REQ-011 SHALL have port resp_valid  output  1  meaning a response is held.
REQ-012 SHALL have port resp_ready  input  1  meaning the initiator consumes the response.
REQ-013 SHALL have port resp_rdata  output  WIDTH  meaning extended load data; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  meaning the request was illegal and had no memory effect.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-016 SHALL latch we/funct3/addr/wdata on the edge where req_valid && req_ready, and load the latency counter with LATENCY-1.
REQ-017 SHALL go from IDLE to RESP directly when LATENCY==1, otherwise to WAIT; WAIT decrements each cycle and goes to RESP after the counter reaches 0, giving resp_valid exactly LATENCY cycles after acceptance.
REQ-018 SHALL commit a store to the array, and register load data, on the edge entering RESP; never earlier.
REQ-019 SHALL hold resp_rdata and resp_err stable in RESP until resp_valid && resp_ready, then return to IDLE; a new request SHALL NOT be accepted on that same edge (no back-to-back; one idle cycle minimum).
REQ-020 SHALL decode loads: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend; stores: 000 SB, 001 SH, 010 SW; any other code SHALL set resp_err.
REQ-021 SHALL select the byte/half lane by addr[1:0] (byte) or addr[1] (half), and write only the addressed bytes with req_wdata[7:0] or [15:0].
REQ-022 SHALL set resp_err with no write when addr >= DEPTH_WORDS*4; the word index is addr[$clog2(DEPTH_WORDS)+1:2].
REQ-023 SHALL ignore req_valid and all request fields outside IDLE; request fields SHALL be used only from the latch.

Reset
REQ-024 SHALL, on rst, force state IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 1 on the following cycle.
REQ-025 SHALL, when rst is asserted mid-operation (WAIT or RESP), abandon the transaction with no array write and no response; array contents SHALL NOT be cleared by reset.

Configuration
REQ-026 SHALL, with DMEM_ALIGN_CHECK_EN defined, set resp_err with no memory effect for a halfword at an odd address or a word with addr[1:0]!=0.
REQ-027 SHALL, without DMEM_ALIGN_CHECK_EN, force misaligned addresses down to natural alignment (clear addr[0] for halfwords, addr[1:0] for words) and never raise resp_err for alignment.

Structure
REQ-028 SHALL take WIDTH and the funct3 load/store codes (LS_B, LS_H, LS_W, LS_BU, LS_HU) and the enum dmem_state_t {IDLE, WAIT, RESP} from all_pkgs.
REQ-029 SHALL place load extraction/extension and store byte-enable/data-lane generation in one combinational sub-module, dmem_lane_unit.

Verification
REQ-030 SHALL cover: LATENCY=2, SW 0xDEADBEEF to 0x10, then LW from 0x10 -> resp_valid 2 cycles after each accept, rdata 0xDEADBEEF.
REQ-031 SHALL cover: SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, LW 0x10 -> 0x80ADBEEF.
REQ-032 SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready 0, and a second req_valid is not accepted.
REQ-033 SHALL cover: SW to DEPTH_WORDS*4, then LW with funct3=011 -> resp_err 1 and rdata 0 for both, with array unchanged.
REQ-034 SHALL cover: LH at 0x11 -> resp_err 1 with DMEM_ALIGN_CHECK_EN, and data from 0x10 without it.
REQ-035 SHALL cover: rst asserted in WAIT during SW 0x1 to 0x20 -> no response, req_ready 1 the next cycle, and a later LW 0x20 returns the old value.

Source files
------------

// File: rtl/all_pkgs.sv
// all_pkgs: shared data width, RV32I load/store funct3 codes and responder FSM states.
package all_pkgs;
   localparam int WIDTH = 32;
   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: load lane extract/extend and store byte-enable/lane replication.
// DMEM_ALIGN_CHECK_EN flags misaligned halfword/word accesses instead of aligning them down.
module dmem_lane_unit import all_pkgs::*; (
   input  logic             we,
   input  logic [2:0]       funct3,
   input  logic [1:0]       off,
   input  logic [WIDTH-1:0] wdata,
   input  logic [WIDTH-1:0] rword,
   output logic [WIDTH-1:0] rdata,
   output logic [3:0]       be,
   output logic [WIDTH-1:0] wword,
   output logic             bad
);
   logic [1:0]  eoff;
   logic [7:0]  b;
   logic [15:0] h;
   logic        bad_code;
   assign bad_code = we ? !(funct3 == LS_B || funct3 == LS_H || funct3 == LS_W)
                        : !(funct3 == LS_B || funct3 == LS_H || funct3 == LS_W ||
                            funct3 == LS_BU || funct3 == LS_HU);
`ifdef DMEM_ALIGN_CHECK_EN
   assign eoff = off;
   assign bad  = bad_code || (funct3[0] && off[0]) || (funct3[1] && off != 2'b00);
`else
   assign eoff = funct3[1] ? 2'b00 : funct3[0] ? {off[1], 1'b0} : off;
   assign bad  = bad_code;
`endif
   assign b = rword[{eoff, 3'b000} +: 8];
   assign h = rword[{eoff[1], 4'b0000} +: 16];
   always_comb begin
      rdata = funct3 == LS_B  ? {{(WIDTH-8){b[7]}}, b} :
              funct3 == LS_H  ? {{(WIDTH-16){h[15]}}, h} :
              funct3 == LS_W  ? rword :
              funct3 == LS_BU ? {{(WIDTH-8){1'b0}}, b} :
              funct3 == LS_HU ? {{(WIDTH-16){1'b0}}, h} : '0;
      be    = funct3 == LS_B ? 4'b0001 << eoff :
              funct3 == LS_H ? (eoff[1] ? 4'b1100 : 4'b0011) :
              funct3 == LS_W ? 4'b1111 : 4'b0000;
      wword = funct3 == LS_B ? {4{wdata[7:0]}} :
              funct3 == LS_H ? {2{wdata[15:0]}} : wdata;
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency RV32 data memory responder with valid/ready request and response.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with resp_err.
module dmem_responder import all_pkgs::*; #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   dmem_state_t      state, state_n;
   logic [3:0]       cnt, cnt_n;
   logic             l_we, c_we, accept, enter_resp, err, bad;
   logic [2:0]       l_f3, c_f3;
   logic [WIDTH-1:0] l_addr, l_wdata, c_addr, c_wdata, ld_data, wword;
   logic [3:0]       be;
   logic [AW-1:0]    idx;
   logic [WIDTH-1:0] mem [DEPTH_WORDS];
   assign req_ready  = state == IDLE;
   assign resp_valid = state == RESP;
   assign accept     = state == IDLE && req_valid;
   // With LATENCY==1 the commit edge is the accept edge, so the live request feeds the datapath.
   assign c_we    = state == IDLE ? req_we     : l_we;
   assign c_f3    = state == IDLE ? req_funct3 : l_f3;
   assign c_addr  = state == IDLE ? req_addr   : l_addr;
   assign c_wdata = state == IDLE ? req_wdata  : l_wdata;
   assign idx     = c_addr[AW+1:2];
   assign err     = bad || c_addr >= WIDTH'(DEPTH_WORDS * 4);
   dmem_lane_unit u_lane (
      .we(c_we), .funct3(c_f3), .off(c_addr[1:0]), .wdata(c_wdata), .rword(mem[idx]),
      .rdata(ld_data), .be(be), .wword(wword), .bad(bad)
   );
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: if (req_valid) begin
            enter_resp = LATENCY == 1;
            state_n    = LATENCY == 1 ? RESP : WAIT;
            cnt_n      = 4'(LATENCY - 1);
         end
         WAIT: begin
            enter_resp = cnt <= 4'd1;
            cnt_n      = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            state_n    = enter_resp ? RESP : WAIT;
         end
         RESP: state_n = resp_ready ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (enter_resp) begin
            resp_rdata <= (err || c_we) ? '0 : ld_data;
            resp_err   <= err;
         end
      end
   end
   always_ff @(posedge clk)
      if (accept) begin
         l_we    <= req_we;
         l_f3    <= req_funct3;
         l_addr  <= req_addr;
         l_wdata <= req_wdata;
      end
   always_ff @(posedge clk)
      if (!rst && enter_resp && !err && c_we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with a byte-array reference model checked every cycle.
module tb_dmem_responder;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_ready = 1'b0, resp_err;
   logic [31:0] resp_rdata;
   int          checks = 0, errors = 0;
   bit          chk_en = 1'b0;
   logic [7:0]  bm [DEPTH*4];
   bit          pend = 1'b0;
   int          age = 0;
   logic        p_we, e_err;
   logic [2:0]  p_f3;
   logic [31:0] p_a, p_wd, e_rd;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] ea;
      bit legal;
      n = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
      legal = we ? f3 <= 3'd2 : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef DMEM_ALIGN_CHECK_EN
      er = !legal || a >= DEPTH*4 || (a % n) != 0;
      ea = a;
`else
      er = !legal || a >= DEPTH*4;
      ea = a - a % n;
`endif
      rd = '0;
      if (er) return;
      if (we) for (int i = 0; i < n; i++) bm[ea+i] = wd[8*i +: 8];
      else begin
         for (int i = 0; i < n; i++) rd[8*i +: 8] = bm[ea+i];
         if (!f3[2] && n < 4 && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8*n);
      end
   endfunction

   // Reference timing: a request taken while idle is answered LAT cycles later and memory
   // changes only when the answer becomes due; reset drops whatever is in flight.
   always @(negedge clk) if (chk_en) begin
      if (pend) begin
         age++;
         if (age == LAT) model(p_we, p_f3, p_a, p_wd, e_rd, e_err);
      end
      chk("req_ready", {31'd0, req_ready}, {31'd0, !pend});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, pend && age >= LAT});
      if (pend && age >= LAT) begin
         chk("resp_rdata", resp_rdata, e_rd);
         chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
      end
      if (rst) pend = 1'b0;
      else if (pend && age >= LAT && resp_ready) pend = 1'b0;
      else if (!pend && req_valid) begin
         pend = 1'b1; age = 0;
         p_we = req_we; p_f3 = req_funct3; p_a = req_addr; p_wd = req_wdata;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic xact(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int hold, input logic [31:0] x_rd, input logic x_er);
      int t, lat;
      logic [31:0] first;
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      t = 0;
      while (!req_ready && t < 50) begin step; t++; end
      step;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 50) begin step; lat++; end
      chk({nm, "_latency"}, lat, LAT);
      first = resp_rdata;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
         step;
         chk({nm, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
         chk({nm, "_hold_rdata"}, resp_rdata, first);
         chk({nm, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
      end
      chk({nm, "_rdata"}, resp_rdata, x_rd);
      chk({nm, "_err"}, {31'd0, resp_err}, {31'd0, x_er});
      req_valid = 1'b0;
      resp_ready = 1'b1;
      step;
      resp_ready = 1'b0;
      step;
   endtask

   initial begin
      repeat (3) step;
      rst = 1'b0;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk_en = 1'b1;
      xact("sw10", 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0, 0);
      xact("lw10", 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0);
      xact("sb13", 1, 3'd0, 32'h13, 32'h80, 0, 32'h0, 0);
      xact("lb13", 0, 3'd0, 32'h13, 32'h0, 0, 32'hFFFFFF80, 0);
      xact("lbu13", 0, 3'd4, 32'h13, 32'h0, 0, 32'h00000080, 0);
      xact("lw10b", 0, 3'd2, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0);
      xact("lwhold", 0, 3'd2, 32'h10, 32'h0, 5, 32'h80ADBEEF, 0);
      xact("lw10c", 0, 3'd2, 32'h10, 32'h0, 0, 32'h80ADBEEF, 0);
      xact("sw0", 1, 3'd2, 32'h0, 32'h11111111, 0, 32'h0, 0);
      xact("sw_oob", 1, 3'd2, DEPTH*4, 32'h22222222, 0, 32'h0, 1);
      xact("lw_f011", 0, 3'd3, 32'h0, 32'h0, 0, 32'h0, 1);
      xact("lw0", 0, 3'd2, 32'h0, 32'h0, 0, 32'h11111111, 0);
      xact("sh_f5", 1, 3'd5, 32'h0, 32'h0, 0, 32'h0, 1);
`ifdef DMEM_ALIGN_CHECK_EN
      xact("lh11", 0, 3'd1, 32'h11, 32'h0, 0, 32'h0, 1);
      xact("sw_mis", 1, 3'd2, 32'h2, 32'h33333333, 0, 32'h0, 1);
`else
      xact("lh11", 0, 3'd1, 32'h11, 32'h0, 0, 32'hFFFFBEEF, 0);
      xact("sw_mis", 1, 3'd2, 32'h2, 32'h33333333, 0, 32'h0, 0);
`endif
      xact("lw0b", 0, 3'd2, 32'h0, 32'h0, 0, 32'h33333333 ^ 32'h33333333 ^
`ifdef DMEM_ALIGN_CHECK_EN
           32'h11111111, 0);
`else
           32'h33333333, 0);
`endif
      xact("sw20", 1, 3'd2, 32'h20, 32'hCAFEF00D, 0, 32'h0, 0);
      xact("sh22", 1, 3'd1, 32'h22, 32'h0000ABCD, 0, 32'h0, 0);
      xact("lhu22", 0, 3'd5, 32'h22, 32'h0, 0, 32'h0000ABCD, 0);
      xact("lh22", 0, 3'd1, 32'h22, 32'h0, 0, 32'hFFFFABCD, 0);
      xact("lbu21", 0, 3'd4, 32'h21, 32'h0, 0, 32'h000000F0, 0);
      req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'h1; req_valid = 1'b1;
      step;
      req_valid = 1'b0;
      chk("mid_wait_valid", {31'd0, resp_valid}, 32'd0);
      rst = 1'b1;
      step;
      rst = 1'b0;
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
      step;
      chk("mid_rst_idle", {31'd0, resp_valid}, 32'd0);
      xact("lw20", 0, 3'd2, 32'h20, 32'h0, 0, 32'hABCDF00D, 0);
      repeat (3) step;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end
endmodule
